// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle load/store controller between the RV32I datapath
// and a word-wide data RAM (combinational read, synchronous word write).
// Byte and halfword stores are done as read-modify-write of the whole word;
// faulting requests are answered without ever starting a RAM cycle.
module data_mem_ctrl #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RSP
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        ram_we_q, ram_we_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;

    logic        req_fault;

    // Stores only know B/H/W; loads additionally have the unsigned B/H forms.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (we) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (f3[1:0])
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Word index beyond the end of the RAM.
    function automatic logic out_of_range(input logic [31:0] addr);
        return ({2'b00, addr[31:2]} >= MEM_WORDS_U);
    endfunction

    // Pick the addressed lane out of a RAM word and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  lo,
                                                input logic [31:0] word);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] res;
        lane_b = word[{lo, 3'b000} +: 8];
        lane_h = word[{lo[1], 4'b0000} +: 16];
        case (f3)
            F3_B:    res = {{24{lane_b[7]}}, lane_b};
            F3_H:    res = {{16{lane_h[15]}}, lane_h};
            F3_W:    res = word;
            F3_BU:   res = {24'h000000, lane_b};
            F3_HU:   res = {16'h0000, lane_h};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Replace only the addressed lane of the old word with the store data.
    function automatic logic [31:0] merge_store(input logic [2:0]  f3,
                                                input logic [1:0]  lo,
                                                input logic [31:0] word,
                                                input logic [31:0] wdata);
        logic [31:0] res;
        res = word;
        case (f3)
            F3_B:    res[{lo, 3'b000} +: 8] = wdata[7:0];
            F3_H:    res[{lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

    // Fault check on the live request; only meaningful in IDLE at acceptance.
    always_comb begin
        req_fault = !funct3_legal(req_we, req_funct3) ||
                    misaligned(req_funct3, req_addr[1:0]) ||
                    out_of_range(req_addr);
    end

    // Next-state logic: sequencing, request capture and registered outputs.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_fault) begin
                        state_d     = ST_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0000_0000;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        state_d     = ST_WR;
                        ram_we_d    = 1'b1;
                        ram_wdata_d = req_wdata;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                word_d = ram_rdata;
                if (!we_q) begin
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_extend(funct3_q, addr_q[1:0], ram_rdata);
                end else begin
                    state_d     = ST_WR;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = merge_store(funct3_q, addr_q[1:0], ram_rdata, wdata_q);
                end
            end
            ST_WR: begin
                state_d     = ST_RSP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'h0000_0000;
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            word_q      <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Output drive: ready while idle, RAM always addressed at the latched word.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = rsp_valid_q;
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
        ram_we    = ram_we_q;
        ram_addr  = {addr_q[31:2], 2'b00};
        ram_wdata = ram_wdata_q;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed load/store vectors against data_mem_ctrl with a
// behavioural RAM; expected responses and RAM writes go into queues that a
// separate monitor drains whenever the controller presents them.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    rsp_exp_t    rsp_q[$];
    wr_exp_t     wr_q[$];
    logic [31:0] mem [0:255];
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    data_mem_ctrl #(.MEM_WORDS(256)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure response latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: combinational read, synchronous write.
    assign ram_rdata = mem[ram_addr[9:2]];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Monitor: compare every response and RAM write against the queued expectations.
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            if (rsp_q.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 expected none");
            end else begin
                rsp_exp_t e;
                e = rsp_q.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                checkOutput("rsp_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (reset_n && ram_we) begin
            if (wr_q.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL unexpected_write: got ram_we=1 addr 0x%08h expected none", ram_addr);
            end else begin
                wr_exp_t w;
                w = wr_q.pop_front();
                checkOutput("ram_addr", ram_addr, w.addr);
                checkOutput("ram_wdata", ram_wdata, w.data);
            end
        end
    end

    // Issue one request, queue its expected response/write and wait until both drain.
    task automatic applyStimulus(input logic        we,
                                 input logic [2:0]  f3,
                                 input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata,
                                 input logic        exp_err,
                                 input int          lat,
                                 input logic        exp_wr,
                                 input logic [31:0] exp_wdata);
        int n;
        rsp_exp_t e;
        wr_exp_t  w;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total_cnt++;
            $display("[TB] FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc + lat;
        rsp_q.push_back(e);
        if (exp_wr) begin
            w.addr = {addr[31:2], 2'b00};
            w.data = exp_wdata;
            wr_q.push_back(w);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        checkOutput("rsp_drained", 32'(rsp_q.size()), 32'd0);
        checkOutput("wr_drained", 32'(wr_q.size()), 32'd0);
        rsp_q.delete();
        wr_q.delete();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
        mem[1]   = 32'h8000_80F0;
        mem[2]   = 32'h1122_3344;
        mem[3]   = 32'hCAFE_F00D;
        mem[255] = 32'h5A5A_00FF;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        #1;
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        checkOutput("reset_ram_we", {31'd0, ram_we}, 32'd0);
        checkOutput("reset_ram_wdata", ram_wdata, 32'd0);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Loads from RAM[1] = 0x8000_80F0 with sign/zero extension.
        applyStimulus(1'b0, 3'b000, 32'h4, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b100, 32'h4, 32'h0, 32'h0000_00F0, 1'b0, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b101, 32'h6, 32'h0, 32'h0000_8000, 1'b0, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF_8000, 1'b0, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b000, 32'h7, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b100, 32'h5, 32'h0, 32'h0000_0080, 1'b0, 2, 1'b0, 32'h0);

        // SB into RAM[2] = 0x1122_3344 lane 2; upper wdata bits must be ignored.
        applyStimulus(1'b1, 3'b000, 32'hA, 32'hFFFF_FFAB, 32'h0, 1'b0, 3, 1'b1, 32'h11AB_3344);
        applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 32'h11AB_3344, 1'b0, 2, 1'b0, 32'h0);

        // SW then LW back.
        applyStimulus(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, 32'h0);

        // SH into upper half of RAM[3] = 0xCAFE_F00D, then halfword loads.
        applyStimulus(1'b1, 3'b001, 32'hE, 32'h5555_1234, 32'h0, 1'b0, 3, 1'b1, 32'h1234_F00D);
        applyStimulus(1'b0, 3'b001, 32'hE, 32'h0, 32'h0000_1234, 1'b0, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b101, 32'hC, 32'h0, 32'h0000_F00D, 1'b0, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b001, 32'hC, 32'h0, 32'hFFFF_F00D, 1'b0, 2, 1'b0, 32'h0);

        // Last legal word.
        applyStimulus(1'b0, 3'b010, 32'h3FC, 32'h0, 32'h5A5A_00FF, 1'b0, 2, 1'b0, 32'h0);

        // Faulting requests: 1-cycle error response, no RAM write.
        applyStimulus(1'b0, 3'b010, 32'h6,   32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        applyStimulus(1'b1, 3'b001, 32'h3,   32'h1234, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b011, 32'h0,   32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        applyStimulus(1'b1, 3'b100, 32'h0,   32'h77, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        applyStimulus(1'b1, 3'b010, 32'h400, 32'h77, 32'h0, 1'b1, 1, 1'b0, 32'h0);

        // SB aborted by reset during its WR cycle; RAM[2] must keep 0xDEAD_BEEF.
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h9;
        req_wdata  = 32'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!ram_we && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("abort_reached_wr", {31'd0, ram_we}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_ram_we", {31'd0, ram_we}, 32'd0);
        checkOutput("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
